// File: rtl/tinyalu_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tinyalu_pkg : shared opcode encoding and responder state/constants        |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
package tinyalu_pkg;

    typedef enum logic [2:0] {
        no_op  = 3'b000,
        add_op = 3'b001,
        and_op = 3'b010,
        xor_op = 3'b011,
        mul_op = 3'b100,
        rst_op = 3'b111
    } operation_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } resp_state_t;

    localparam int MUL_STEPS = 8;

endpackage
`default_nettype wire

// File: rtl/tinyalu_mul_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tinyalu_mul_seq : 8x8 unsigned shift-add multiplier, 8 steps after load   |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module tinyalu_mul_seq
    import tinyalu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic        busy,
    output logic [15:0] product
);

    logic [15:0] mcand;
    logic [7:0]  mplier;
    logic [15:0] acc;
    logic [3:0]  count;

    assign busy = (count != 4'd0);

    // Accumulator value after the step taken this cycle; once the multiplier
    // is exhausted it stays equal to the finished product.
    assign product = acc + (mplier[0] ? mcand : 16'h0000);

    always_ff @(posedge clk) begin
        if (reset) begin
            mcand  <= 16'h0000;
            mplier <= 8'h00;
            acc    <= 16'h0000;
            count  <= 4'd0;
        end else if (load) begin
            mcand  <= {8'h00, a};
            mplier <= b;
            acc    <= 16'h0000;
            count  <= 4'(MUL_STEPS);
        end else if (busy) begin
            acc    <= product;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            count  <= count - 4'd1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/tinyalu_responder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tinyalu_responder : TinyALU start/done responder with sequential multiply |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module tinyalu_responder
    import tinyalu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  A,
    input  logic [7:0]  B,
    input  logic [2:0]  op,
    input  logic        start,
    output logic        done,
    output logic [15:0] result
);

    resp_state_t state;
    logic [3:0]  steps_left;
    logic [8:0]  add_sum;
    logic        mul_load;
    logic        mul_clear;
    logic        mul_busy;
    logic [15:0] mul_product;

    assign add_sum   = {1'b0, A} + {1'b0, B};
    assign mul_load  = (state == IDLE) && start && (operation_t'(op) == mul_op);
    // Dropping start mid-multiply wipes the multiplier along with the command.
    assign mul_clear = reset || ((state == MUL) && !start);

    tinyalu_mul_seq u_mul (
        .clk     (clk),
        .reset   (mul_clear),
        .load    (mul_load),
        .a       (A),
        .b       (B),
        .busy    (mul_busy),
        .product (mul_product)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            done       <= 1'b0;
            result     <= 16'h0000;
            steps_left <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        case (operation_t'(op))
                            add_op: begin
                                result <= {7'b0, add_sum};
                                done   <= 1'b1;
                                state  <= DONE;
                            end
                            and_op: begin
                                result <= {8'h00, A & B};
                                done   <= 1'b1;
                                state  <= DONE;
                            end
                            xor_op: begin
                                result <= {8'h00, A ^ B};
                                done   <= 1'b1;
                                state  <= DONE;
                            end
                            mul_op: begin
                                steps_left <= 4'(MUL_STEPS);
                                state      <= MUL;
                            end
                            rst_op: begin
                                result <= 16'h0000;
                            end
                            default: begin
                                done  <= 1'b1;
                                state <= DONE;
                            end
                        endcase
                    end
                end
                MUL: begin
                    if (!start) begin
                        state <= IDLE;
                    end else if (mul_busy && (steps_left == 4'd1)) begin
                        result <= mul_product;
                        done   <= 1'b1;
                        state  <= DONE;
                    end else begin
                        steps_left <= steps_left - 4'd1;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_tinyalu_responder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_tinyalu_responder : directed vectors with queue-based result checking  |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module tb_tinyalu_responder;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  A = 8'h00;
    logic [7:0]  B = 8'h00;
    logic [2:0]  op = 3'b000;
    logic        start = 1'b0;
    logic        done;
    logic [15:0] result;

    int compared = 0;
    int mismatched = 0;
    int cyc = 0;
    logic prev_done = 1'b0;

    typedef struct {
        logic [15:0] res;
        int          due;
    } exp_t;
    exp_t expq[$];

    tinyalu_responder dut (
        .clk    (clk),
        .reset  (reset),
        .A      (A),
        .B      (B),
        .op     (op),
        .start  (start),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every done pulse must match the oldest pending expectation.
    always @(negedge clk) begin
        if (done) begin
            compared = compared + 1;
            if (prev_done) begin
                mismatched = mismatched + 1;
                $display("FAIL done_back_to_back: done high on cycle %0d and %0d", cyc - 1, cyc);
            end
            if (expq.size() == 0) begin
                mismatched = mismatched + 1;
                $display("FAIL unexpected_done: got done at cycle %0d result=%h, required no done", cyc, result);
            end else begin
                exp_t e;
                e = expq.pop_front();
                if (result !== e.res || cyc != e.due) begin
                    mismatched = mismatched + 1;
                    $display("FAIL done_result: got %h at cycle %0d, required %h at cycle %0d",
                             result, cyc, e.res, e.due);
                end
            end
        end
        prev_done = done;
    end

    task automatic check_now(input string name, input logic [15:0] exp_res);
        compared = compared + 1;
        if (result !== exp_res || done !== 1'b0) begin
            mismatched = mismatched + 1;
            $display("FAIL %s: got result=%h done=%b, required result=%h done=0", name, result, done, exp_res);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called just after a clock edge; holds start until the DONE cycle.
    task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic [2:0] o,
                         input bit exp_done, input logic [15:0] exp_res, input int lat);
        exp_t e;
        A = a; B = b; op = o; start = 1'b1;
        if (exp_done) begin
            e.res = exp_res;
            e.due = cyc + lat;
            expq.push_back(e);
        end
        repeat (lat) tick();
        start = 1'b0;
        tick();
    endtask

    initial begin
        repeat (2) tick();
        check_now("reset_hold", 16'h0000);
        reset = 1'b0;
        repeat (2) tick();
        check_now("idle_after_reset", 16'h0000);

        issue(8'hFF, 8'hFF, 3'b001, 1, 16'h01FE, 1);
        issue(8'hA5, 8'hFF, 3'b011, 1, 16'h005A, 1);
        issue(8'hF0, 8'h3C, 3'b010, 1, 16'h0030, 1);
        issue(8'hFF, 8'hFF, 3'b100, 1, 16'hFE01, 9);
        issue(8'h0D, 8'h0B, 3'b100, 1, 16'h008F, 9);
        issue(8'h00, 8'h7F, 3'b100, 1, 16'h0000, 9);
        issue(8'h0F, 8'h03, 3'b011, 1, 16'h000C, 1);

        // Abort: start held for E0..E3, dropped before E4.
        A = 8'h12; B = 8'h34; op = 3'b100; start = 1'b1;
        repeat (4) tick();
        start = 1'b0;
        repeat (12) tick();
        check_now("mul_abort_keeps_result", 16'h000C);
        issue(8'h01, 8'h01, 3'b001, 1, 16'h0002, 1);

        // Reset lands on the fifth multiply edge.
        A = 8'h12; B = 8'h34; op = 3'b100; start = 1'b1;
        repeat (5) tick();
        reset = 1'b1;
        start = 1'b0;
        tick();
        check_now("reset_mid_mul", 16'h0000);
        reset = 1'b0;
        repeat (10) tick();
        check_now("after_mid_mul_reset", 16'h0000);

        issue(8'h30, 8'h40, 3'b001, 1, 16'h0070, 1);
        issue(8'h55, 8'h66, 3'b111, 0, 16'h0000, 1);
        check_now("rst_op_clears", 16'h0000);

        issue(8'h05, 8'h06, 3'b001, 1, 16'h000B, 1);
        issue(8'h77, 8'h88, 3'b110, 1, 16'h000B, 1);
        issue(8'h99, 8'h11, 3'b000, 1, 16'h000B, 1);
        issue(8'h02, 8'h03, 3'b101, 1, 16'h000B, 1);
        check_now("no_op_keeps_result", 16'h000B);

        repeat (5) tick();
        compared = compared + 1;
        if (expq.size() != 0) begin
            mismatched = mismatched + 1;
            $display("FAIL missing_done: %0d expected completions never seen, required 0", expq.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
`default_nettype wire
